divider_arbiter: RTL and testbench

DIVIDER_ARBITER -- requirements
Module: divider_arbiter

---
 rtl/divider_arbiter_pkg.sv | 15 +
 rtl/divider_arbiter_round_robin_picker.sv | 40 ++++
 rtl/divider_arbiter.sv | 123 ++++++++++++
 tb/tb_divider_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_arbiter_pkg.sv
// Shared types and constants for the divider arbiter: FSM encoding and the
// quotient reported for a divide-by-zero request.
package divider_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } arb_state_t;

    // All-ones quotient for x/0; sliced down to the operand width (WIDTH <= 64).
    localparam logic [63:0] DIV0_QUOTIENT = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/divider_arbiter_round_robin_picker.sv
// Combinational round-robin picker: searches from last_owner+1 upward with
// wrap-around and returns the first active request as one-hot and index.
module round_robin_picker
    import divider_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDXW   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDXW-1:0]    i_last,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDXW-1:0]    o_idx,
    output logic               o_any
);

    int              w_cand;
    logic [IDXW-1:0] w_cand_idx;
    logic            w_found;

    always_comb begin
        w_found    = 1'b0;
        w_cand     = 0;
        w_cand_idx = '0;
        o_idx      = '0;
        o_onehot   = '0;
        // Offset NUM_REQ lands back on last_owner, so it has lowest priority.
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_cand     = (int'(i_last) + off) % NUM_REQ;
            w_cand_idx = IDXW'(w_cand);
            if (!w_found && i_req[w_cand_idx]) begin
                w_found = 1'b1;
                o_idx   = w_cand_idx;
            end
        end
        if (w_found) o_onehot[o_idx] = 1'b1;
    end

    assign o_any = w_found;

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one external divider among NUM_REQ requesters;
// one division in flight, divide-by-zero answered locally without the divider.
module divider_arbiter
    import divider_arbiter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*WIDTH-1:0] i_dividend,
    input  logic [NUM_REQ*WIDTH-1:0] i_divisor,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic [NUM_REQ-1:0]       o_valid,
    output logic [WIDTH-1:0]         o_quotient,
    output logic [WIDTH-1:0]         o_remainder,
    output logic                     o_busy,
    output logic                     o_div_start,
    output logic [WIDTH-1:0]         o_div_dividend,
    output logic [WIDTH-1:0]         o_div_divisor,
    input  logic                     i_div_ready,
    input  logic                     i_div_valid,
    input  logic [WIDTH-1:0]         i_div_quotient,
    input  logic [WIDTH-1:0]         i_div_remainder
);

    localparam int IDXW = $clog2(NUM_REQ);

    arb_state_t         r_state;
    logic [IDXW-1:0]    r_owner, r_last;
    logic [NUM_REQ-1:0] r_grant, r_valid;
    logic [WIDTH-1:0]   r_quot, r_rem, r_dvd, r_dvs;
    logic               r_start, r_busy;

    logic [NUM_REQ-1:0] w_win_onehot, w_owner_onehot;
    logic [IDXW-1:0]    w_win_idx;
    logic               w_any;
    logic [WIDTH-1:0]   w_sel_dvd, w_sel_dvs;

    round_robin_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .i_req    (i_req),
        .i_last   (r_last),
        .o_onehot (w_win_onehot),
        .o_idx    (w_win_idx),
        .o_any    (w_any)
    );

    assign w_sel_dvd      = i_dividend[int'(w_win_idx)*WIDTH +: WIDTH];
    assign w_sel_dvs      = i_divisor[int'(w_win_idx)*WIDTH +: WIDTH];
    assign w_owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;

    // Start is decided at capture so it lines up with the ISSUE cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_last  <= IDXW'(NUM_REQ-1);
            r_grant <= '0;
            r_valid <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_grant <= '0;
            r_valid <= '0;
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any && i_div_ready) begin
                        r_owner <= w_win_idx;
                        r_dvd   <= w_sel_dvd;
                        r_dvs   <= w_sel_dvs;
                        r_grant <= w_win_onehot;
                        r_start <= (w_sel_dvs != '0);
                        r_busy  <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_dvs == '0) begin
                        r_quot  <= DIV0_QUOTIENT[WIDTH-1:0];
                        r_rem   <= r_dvd;
                        r_valid <= w_owner_onehot;
                        r_state <= ST_RESPOND;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_div_valid) begin
                        r_quot  <= i_div_quotient;
                        r_rem   <= i_div_remainder;
                        r_valid <= w_owner_onehot;
                        r_state <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    // Result bus returns to zero once the pulse is over.
                    r_quot  <= '0;
                    r_rem   <= '0;
                    r_last  <= r_owner;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_grant        = r_grant;
    assign o_valid        = r_valid;
    assign o_quotient     = r_quot;
    assign o_remainder    = r_rem;
    assign o_busy         = r_busy;
    assign o_div_start    = r_start;
    assign o_div_dividend = r_dvd;
    assign o_div_divisor  = r_dvs;

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter with a small fixed-latency divider model;
// expected results are hand-computed constants.
module tb_divider_arbiter;

    localparam int W = 32;
    localparam int N = 4;

    logic           i_clk = 1'b0;
    logic           i_reset_n;
    logic [N-1:0]   i_req;
    logic [N*W-1:0] i_dividend, i_divisor;
    logic [N-1:0]   o_grant, o_valid;
    logic [W-1:0]   o_quotient, o_remainder;
    logic           o_busy, o_div_start;
    logic [W-1:0]   o_div_dividend, o_div_divisor;
    logic           i_div_ready, i_div_valid;
    logic [W-1:0]   i_div_quotient, i_div_remainder;

    int n_assert = 0;
    int n_fail   = 0;

    // divider model: result two cycles after the start is seen
    int           m_cnt;
    int           n_starts;
    logic [W-1:0] m_a, m_b, m_q, m_r;
    logic         m_valid;
    logic         sp_valid;

    assign i_div_valid     = m_valid | sp_valid;
    assign i_div_quotient  = sp_valid ? 32'hDEAD_BEEF : m_q;
    assign i_div_remainder = sp_valid ? 32'hBAAD_F00D : m_r;

    divider_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .i_clk           (i_clk),
        .i_reset_n       (i_reset_n),
        .i_req           (i_req),
        .i_dividend      (i_dividend),
        .i_divisor       (i_divisor),
        .o_grant         (o_grant),
        .o_valid         (o_valid),
        .o_quotient      (o_quotient),
        .o_remainder     (o_remainder),
        .o_busy          (o_busy),
        .o_div_start     (o_div_start),
        .o_div_dividend  (o_div_dividend),
        .o_div_divisor   (o_div_divisor),
        .i_div_ready     (i_div_ready),
        .i_div_valid     (i_div_valid),
        .i_div_quotient  (i_div_quotient),
        .i_div_remainder (i_div_remainder)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            m_cnt   <= 0;
            m_valid <= 1'b0;
            m_a     <= '0;
            m_b     <= '0;
            m_q     <= '0;
            m_r     <= '0;
        end else begin
            m_valid <= 1'b0;
            if (o_div_start) begin
                m_cnt    <= 2;
                m_a      <= o_div_dividend;
                m_b      <= o_div_divisor;
                n_starts <= n_starts + 1;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1 && m_b != 0) begin
                    m_valid <= 1'b1;
                    m_q     <= m_a / m_b;
                    m_r     <= m_a % m_b;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic set_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        i_dividend[k*W +: W] = a;
        i_divisor[k*W +: W]  = b;
    endtask

    task automatic wait_grant(input int maxc, output int cyc);
        cyc = 0;
        while (o_grant == '0 && cyc < maxc) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_valid(input int maxc, output int cyc);
        cyc = 0;
        while (o_valid == '0 && cyc < maxc) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int           cyc;
        int           cnt;
        int           s0;
        logic [N-1:0] eg;
        logic [W-1:0] exp_q [4];
        logic [W-1:0] exp_r [4];

        n_starts    = 0;
        i_reset_n   = 1'b0;
        i_req       = '0;
        i_dividend  = '0;
        i_divisor   = '0;
        i_div_ready = 1'b1;
        sp_valid    = 1'b0;
        repeat (2) tick();

        // reset state
        check("rst_busy",  64'(o_busy), 64'd0);
        check("rst_grant", 64'(o_grant), 64'd0);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_start", 64'(o_div_start), 64'd0);
        check("rst_quot",  64'(o_quotient), 64'd0);
        check("rst_dvd",   64'(o_div_dividend), 64'd0);
        i_reset_n = 1'b1;
        tick();

        // single request 100/7
        set_op(0, 32'd100, 32'd7);
        i_req = 4'b0001;
        tick();
        check("t1_grant", 64'(o_grant), 64'h1);
        check("t1_start", 64'(o_div_start), 64'd1);
        check("t1_busy",  64'(o_busy), 64'd1);
        check("t1_dvd",   64'(o_div_dividend), 64'd100);
        check("t1_dvs",   64'(o_div_divisor), 64'd7);
        i_req = '0;
        wait_valid(20, cyc);
        check("t1_latency", 64'(cyc), 64'd4);
        check("t1_valid", 64'(o_valid), 64'h1);
        check("t1_quot",  64'(o_quotient), 64'd14);
        check("t1_rem",   64'(o_remainder), 64'd2);
        check("t1_starts", 64'(n_starts), 64'd1);
        tick();
        check("t1_valid_off", 64'(o_valid), 64'd0);
        check("t1_quot_off",  64'(o_quotient), 64'd0);
        check("t1_busy_off",  64'(o_busy), 64'd0);
        check("t1_dvd_hold",  64'(o_div_dividend), 64'd100);

        // all four requesting from reset: order 0,1,2,3,0
        i_reset_n = 1'b0;
        tick();
        set_op(0, 32'd20, 32'd3);
        set_op(1, 32'd30, 32'd4);
        set_op(2, 32'd41, 32'd5);
        set_op(3, 32'd53, 32'd6);
        exp_q = '{32'd6, 32'd7, 32'd8, 32'd8};
        exp_r = '{32'd2, 32'd2, 32'd1, 32'd5};
        i_req = 4'b1111;
        i_reset_n = 1'b1;
        for (int g = 0; g < 5; g++) begin
            eg = 4'b0001 << (g % 4);
            wait_grant(20, cyc);
            check("rr_grant", 64'(o_grant), 64'(eg));
            wait_valid(20, cyc);
            check("rr_valid", 64'(o_valid), 64'(eg));
            check("rr_quot",  64'(o_quotient), 64'(exp_q[g % 4]));
            check("rr_rem",   64'(o_remainder), 64'(exp_r[g % 4]));
            if (g == 4) i_req = '0;
            tick();
        end
        tick();
        check("rr_busy_end", 64'(o_busy), 64'd0);

        // divide by zero on requester 2
        set_op(2, 32'd55, 32'd0);
        i_req = 4'b0100;
        s0 = n_starts;
        tick();
        check("dz_grant", 64'(o_grant), 64'h4);
        check("dz_start", 64'(o_div_start), 64'd0);
        i_req = '0;
        tick();
        check("dz_valid", 64'(o_valid), 64'h4);
        check("dz_quot",  64'(o_quotient), 64'hFFFF_FFFF);
        check("dz_rem",   64'(o_remainder), 64'd55);
        check("dz_nostart", 64'(n_starts), 64'(s0));
        tick();

        // divider not ready for 10 cycles
        i_div_ready = 1'b0;
        set_op(1, 32'd9, 32'd2);
        i_req = 4'b0010;
        cnt = 0;
        repeat (10) begin
            tick();
            if (o_grant != '0) cnt++;
        end
        check("rdy_nogrant", 64'(cnt), 64'd0);
        i_div_ready = 1'b1;
        tick();
        check("rdy_grant", 64'(o_grant), 64'h2);
        i_req = '0;
        wait_valid(20, cyc);
        check("rdy_quot", 64'(o_quotient), 64'd4);
        check("rdy_rem",  64'(o_remainder), 64'd1);
        tick();

        // reset while waiting on the divider
        set_op(0, 32'd100, 32'd7);
        i_req = 4'b0001;
        tick();
        i_req = '0;
        tick();
        check("mr_busy_pre", 64'(o_busy), 64'd1);
        #2 i_reset_n = 1'b0;
        #1;
        check("mr_busy",  64'(o_busy), 64'd0);
        check("mr_grant", 64'(o_grant), 64'd0);
        check("mr_valid", 64'(o_valid), 64'd0);
        check("mr_start", 64'(o_div_start), 64'd0);
        check("mr_dvd",   64'(o_div_dividend), 64'd0);
        tick();
        i_reset_n = 1'b1;
        tick();
        sp_valid = 1'b1;
        tick();
        sp_valid = 1'b0;
        cnt = 0;
        repeat (8) begin
            if (o_valid != '0) cnt++;
            tick();
        end
        check("mr_no_valid", 64'(cnt), 64'd0);
        check("mr_busy_post", 64'(o_busy), 64'd0);

        // requester 3 withdraws before being granted
        set_op(1, 32'd50, 32'd8);
        set_op(3, 32'd1, 32'd1);
        i_req = 4'b1010;
        tick();
        check("wd_grant", 64'(o_grant), 64'h2);
        i_req = '0;
        wait_valid(20, cyc);
        check("wd_valid", 64'(o_valid), 64'h2);
        check("wd_quot",  64'(o_quotient), 64'd6);
        check("wd_rem",   64'(o_remainder), 64'd2);
        cnt = 0;
        repeat (6) begin
            tick();
            if (o_grant != '0) cnt++;
        end
        check("wd_nogrant", 64'(cnt), 64'd0);
        check("wd_busy", 64'(o_busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
